// File: rtl/stream_pattern_source_pkg.sv
// Shared definitions for the stream pattern source.
// Holds the mode and state encodings, the word signatures, the LFSR polynomial,
// the command field positions and small helpers used by the top and the generator.
package stream_pattern_source_pkg;

  localparam int DATA_W = 128;
  localparam int CNT_W  = 32;

  // Command word field positions
  localparam int CMD_N_LSB    = 0;
  localparam int CMD_SEED_LSB = 32;
  localparam int CMD_MODE_LSB = 64;

  localparam logic [31:0] DATA_SIG    = 32'h42424242;
  localparam logic [31:0] TRAILER_SIG = 32'hDEADBEEF;
  localparam logic [31:0] LFSR_POLY   = 32'h80200003;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    TRAILER = 2'd2
  } state_e;

  // The unused encoding 3 behaves like increment mode.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_LFSR;
      2'd2:    return MODE_CONST;
      default: return MODE_INC;
    endcase
  endfunction

  // One step of the right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/stream_pattern_source_if.sv
// Stream bundle for the pattern source: command stream in, data stream out,
// and the burst status outputs.
//   master : seen by the pattern source (drives s1i_rdy, s1o_*, busy, words_sent)
//   slave  : seen by the host side
interface stream_pattern_source_if;
  import stream_pattern_source_pkg::*;

  logic              s1i_valid;
  logic              s1i_rdy;
  logic [DATA_W-1:0] s1i_data;
  logic              s1o_valid;
  logic              s1o_rdy;
  logic [DATA_W-1:0] s1o_data;
  logic              busy;
  logic [CNT_W-1:0]  words_sent;

  modport master (
    input  s1i_valid, s1i_data, s1o_rdy,
    output s1i_rdy, s1o_valid, s1o_data, busy, words_sent
  );

  modport slave (
    output s1i_valid, s1i_data, s1o_rdy,
    input  s1i_rdy, s1o_valid, s1o_data, busy, words_sent
  );
endinterface

// File: rtl/stream_pattern_gen.sv
// Pattern register for the stream pattern source.
//   clk, rst  : clock and synchronous active-high reset
//   load_i    : load seed_i / mode_i (LFSR mode maps a zero seed to 1)
//   seed_i    : starting pattern value
//   mode_i    : increment, LFSR or constant
//   advance_i : step the pattern to its next value in the loaded mode
//   pat_o     : current pattern value
module stream_pattern_gen
  import stream_pattern_source_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] seed_i,
  input  mode_e       mode_i,
  input  logic        advance_i,
  output logic [31:0] pat_o
);

  logic [31:0] pat_q, pat_d;
  mode_e       mode_q, mode_d;

  // An all-zero LFSR would lock up, so a zero seed starts it at 1.
  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    if (load_i) begin
      mode_d = mode_i;
      pat_d  = (mode_i == MODE_LFSR && seed_i == 32'h0) ? 32'h1 : seed_i;
    end else if (advance_i) begin
      case (mode_q)
        MODE_LFSR:  pat_d = lfsr_next(pat_q);
        MODE_CONST: pat_d = pat_q;
        default:    pat_d = pat_q + 32'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= 32'h0;
      mode_q <= MODE_INC;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
    end
  end

  assign pat_o = pat_q;

endmodule

// File: rtl/stream_pattern_source.sv
// Host-commanded 128-bit stream transmitter. One command word {mode, seed, N}
// starts a burst of N pattern words followed by a trailer carrying the 32-bit
// sum of the patterns sent.
//   clk, rst : shared stream clock, synchronous active-high reset
//   strm_io  : command stream in (s1i_*), data stream out (s1o_*), busy, words_sent
module stream_pattern_source
  import stream_pattern_source_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  stream_pattern_source_if.master  strm_io
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] words_sent_q, words_sent_d;
  logic [CNT_W-1:0] checksum_q, checksum_d;
  logic [31:0]      pat;
  logic             accept, out_hs, data_hs;
  logic             unused_cmd_bits;

  assign unused_cmd_bits = ^strm_io.s1i_data[DATA_W-1:CMD_MODE_LSB+2];

  assign strm_io.s1i_rdy = (state_q == IDLE) && !rst;
  assign accept          = strm_io.s1i_valid && strm_io.s1i_rdy;
  assign out_hs          = strm_io.s1o_valid && strm_io.s1o_rdy;
  assign data_hs         = out_hs && (state_q == DATA);

  stream_pattern_gen u_gen (
    .clk       (clk),
    .rst       (rst),
    .load_i    (accept),
    .seed_i    (strm_io.s1i_data[CMD_SEED_LSB +: 32]),
    .mode_i    (decode_mode(strm_io.s1i_data[CMD_MODE_LSB +: 2])),
    .advance_i (data_hs),
    .pat_o     (pat)
  );

  // Output word is built only from registers, so it holds while stalled.
  always_comb begin
    strm_io.s1o_valid  = (state_q != IDLE);
    strm_io.busy       = (state_q != IDLE);
    strm_io.words_sent = words_sent_q;
    case (state_q)
      DATA:    strm_io.s1o_data = {DATA_SIG, seq_q, ~pat, pat};
      TRAILER: strm_io.s1o_data = {TRAILER_SIG, n_q, 32'h0, checksum_q};
      default: strm_io.s1o_data = '0;
    endcase
  end

  // Next state and counters. The last data word is the one with seq == N-1;
  // seq therefore never wraps even for N = 0xFFFFFFFF.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    seq_d        = seq_q;
    words_sent_d = words_sent_q;
    checksum_d   = checksum_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          n_d          = strm_io.s1i_data[CMD_N_LSB +: CNT_W];
          seq_d        = '0;
          words_sent_d = '0;
          checksum_d   = '0;
          state_d      = (n_d != '0) ? DATA : TRAILER;
        end
      end
      DATA: begin
        if (out_hs) begin
          checksum_d   = checksum_q + pat;
          seq_d        = seq_q + 32'd1;
          words_sent_d = words_sent_q + 32'd1;
          if (seq_q == n_q - 32'd1) state_d = TRAILER;
        end
      end
      TRAILER: begin
        if (out_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      n_q          <= '0;
      seq_q        <= '0;
      words_sent_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      seq_q        <= seq_d;
      words_sent_q <= words_sent_d;
      checksum_q   <= checksum_d;
    end
  end

endmodule

// File: tb/tb_stream_pattern_source.sv
// Self-checking bench for stream_pattern_source. A queue-based model expands
// each accepted command into its expected output words; a compare process
// checks the DUT every cycle, and literal checks pin the captured words.
module tb_stream_pattern_source;

  typedef struct {
    logic [127:0] data;
    bit           isData;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stream_pattern_source_if busIf ();

  stream_pattern_source dut (
    .clk     (clk),
    .rst     (rst),
    .strm_io (busIf)
  );

  always #5 clk = ~clk;

  int           assertCount = 0;
  int           failCount   = 0;
  int           acceptCount = 0;
  bit           armed       = 1'b0;
  word_t        expQ[$];
  logic [127:0] logQ[$];
  logic [31:0]  modelWs     = 32'h0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s: timed out waiting for DUT at %0t", name, $time);
  endtask

  // Expand a command into the words the host must see, straight from the
  // pattern rules: k-th data word, then the trailer with the 32-bit sum.
  task automatic pushCommand(input logic [127:0] cmd);
    logic [31:0] n, seed, p, sum;
    int          mode;
    word_t       w;
    n    = cmd[31:0];
    seed = cmd[63:32];
    mode = int'(cmd[65:64]);
    if (mode == 3) mode = 0;
    p   = (mode == 1 && seed == 32'h0) ? 32'h1 : seed;
    sum = 32'h0;
    for (int k = 0; k < int'(n); k++) begin
      w.data   = {32'h42424242, 32'(k), ~p, p};
      w.isData = 1'b1;
      expQ.push_back(w);
      sum = sum + p;
      if (mode == 0)      p = p + 32'd1;
      else if (mode == 1) p = (p >> 1) ^ (p[0] ? 32'h80200003 : 32'h0);
    end
    w.data   = {32'hDEADBEEF, n, 32'h0, sum};
    w.isData = 1'b0;
    expQ.push_back(w);
  endtask

  // Compare process: check on the falling edge, then advance the model to
  // what the following rising edge will do.
  initial begin
    bit modelRdy;
    forever begin
      @(negedge clk);
      modelRdy = (expQ.size() == 0) && !rst;
      if (armed) begin
        checkOutput("s1i_rdy", 128'(busIf.s1i_rdy), 128'(modelRdy));
        checkOutput("s1o_valid", 128'(busIf.s1o_valid), 128'(expQ.size() != 0));
        checkOutput("busy", 128'(busIf.busy), 128'(expQ.size() != 0));
        checkOutput("words_sent", 128'(busIf.words_sent), 128'(modelWs));
        if (expQ.size() != 0) checkOutput("s1o_data", busIf.s1o_data, expQ[0].data);
      end
      if (rst) begin
        expQ.delete();
        modelWs = 32'h0;
        armed   = 1'b1;
      end else if (armed) begin
        if (expQ.size() != 0 && busIf.s1o_rdy) begin
          logQ.push_back(busIf.s1o_data);
          if (expQ[0].isData) modelWs = modelWs + 32'd1;
          void'(expQ.pop_front());
        end
        if (modelRdy && busIf.s1i_valid) begin
          pushCommand(busIf.s1i_data);
          modelWs = 32'h0;
          acceptCount++;
        end
      end
    end
  end

  // Offer one command and hold it until it is accepted.
  task automatic applyStimulus(input logic [31:0] n, input logic [31:0] seed, input logic [1:0] mode);
    int start;
    int cycles;
    start  = acceptCount;
    cycles = 0;
    busIf.s1i_valid = 1'b1;
    busIf.s1i_data  = {62'h0, mode, seed, n};
    while (acceptCount == start && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (acceptCount == start) reportTimeout("cmd_accept");
    busIf.s1i_valid = 1'b0;
    busIf.s1i_data  = '0;
  endtask

  task automatic waitIdle(input string name);
    int cycles;
    cycles = 0;
    while (expQ.size() != 0 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (expQ.size() != 0) reportTimeout(name);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int cycles;
    busIf.s1i_valid = 1'b0;
    busIf.s1i_data  = '0;
    busIf.s1o_rdy   = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s1i_rdy", 128'(busIf.s1i_rdy), 128'(0));
    rst = 1'b0;
    #1;
    checkOutput("rst_s1o_valid", 128'(busIf.s1o_valid), 128'(0));
    checkOutput("rst_busy", 128'(busIf.busy), 128'(0));
    checkOutput("rst_words_sent", 128'(busIf.words_sent), 128'(0));
    checkOutput("rst_s1i_rdy_after", 128'(busIf.s1i_rdy), 128'(1));

    // Increment mode, N=3
    base = logQ.size();
    applyStimulus(32'd3, 32'h10, 2'd0);
    waitIdle("t1_idle");
    checkOutput("t1_count", 128'(logQ.size() - base), 128'(4));
    checkOutput("t1_w0", logQ[base],   {32'h42424242, 32'd0, 32'hFFFFFFEF, 32'h00000010});
    checkOutput("t1_w2", logQ[base+2], {32'h42424242, 32'd2, 32'hFFFFFFED, 32'h00000012});
    checkOutput("t1_trl", logQ[base+3], {32'hDEADBEEF, 32'd3, 32'h0, 32'h00000033});
    checkOutput("t1_words_sent", 128'(busIf.words_sent), 128'(3));
    checkOutput("t1_rdy_back", 128'(busIf.s1i_rdy), 128'(1));

    // N=0: trailer only
    base = logQ.size();
    applyStimulus(32'd0, 32'h1234, 2'd0);
    waitIdle("t2_idle");
    checkOutput("t2_count", 128'(logQ.size() - base), 128'(1));
    checkOutput("t2_trl", logQ[base], {32'hDEADBEEF, 32'd0, 32'h0, 32'h0});

    // LFSR mode with zero seed
    base = logQ.size();
    applyStimulus(32'd2, 32'h0, 2'd1);
    waitIdle("t3_idle");
    checkOutput("t3_w0", logQ[base],   {32'h42424242, 32'd0, 32'hFFFFFFFE, 32'h00000001});
    checkOutput("t3_w1", logQ[base+1], {32'h42424242, 32'd1, 32'h7FDFFFFC, 32'h80200003});
    checkOutput("t3_trl", logQ[base+2], {32'hDEADBEEF, 32'd2, 32'h0, 32'h80200004});

    // Increment wrap with toggling ready and a 5-cycle stall
    base = logQ.size();
    busIf.s1o_rdy = 1'b0;
    applyStimulus(32'd4, 32'hFFFFFFFE, 2'd0);
    cycles = 0;
    while (expQ.size() != 0 && cycles < 200) begin
      if (cycles < 4)      busIf.s1o_rdy = (cycles % 2 == 0);
      else if (cycles < 9) busIf.s1o_rdy = 1'b0;
      else                 busIf.s1o_rdy = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
    if (expQ.size() != 0) reportTimeout("t4_idle");
    busIf.s1o_rdy = 1'b1;
    checkOutput("t4_w0", logQ[base],   {32'h42424242, 32'd0, 32'h00000001, 32'hFFFFFFFE});
    checkOutput("t4_w1", logQ[base+1], {32'h42424242, 32'd1, 32'h00000000, 32'hFFFFFFFF});
    checkOutput("t4_w2", logQ[base+2], {32'h42424242, 32'd2, 32'hFFFFFFFF, 32'h00000000});
    checkOutput("t4_w3", logQ[base+3], {32'h42424242, 32'd3, 32'hFFFFFFFE, 32'h00000001});
    checkOutput("t4_trl", logQ[base+4], {32'hDEADBEEF, 32'd4, 32'h0, 32'hFFFFFFFE});

    // Second command held during a burst
    base = logQ.size();
    applyStimulus(32'd3, 32'h200, 2'd0);
    applyStimulus(32'd2, 32'h300, 2'd2);
    waitIdle("t5_idle");
    checkOutput("t5_count", 128'(logQ.size() - base), 128'(7));
    checkOutput("t5_trl1", logQ[base+3], {32'hDEADBEEF, 32'd3, 32'h0, 32'h00000603});
    checkOutput("t5_w0b", logQ[base+4], {32'h42424242, 32'd0, 32'hFFFFFCFF, 32'h00000300});
    checkOutput("t5_trl2", logQ[base+6], {32'hDEADBEEF, 32'd2, 32'h0, 32'h00000600});
    checkOutput("t5_words_sent", 128'(busIf.words_sent), 128'(2));

    // Reset mid-burst
    base = logQ.size();
    applyStimulus(32'd5, 32'hA5A5A5A5, 2'd2);
    cycles = 0;
    while (logQ.size() < base + 2 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (logQ.size() < base + 2) reportTimeout("t6_two_words");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("t6_valid", 128'(busIf.s1o_valid), 128'(0));
    checkOutput("t6_busy", 128'(busIf.busy), 128'(0));
    checkOutput("t6_words_sent", 128'(busIf.words_sent), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_no_trailer", 128'(logQ.size() - base), 128'(2));
    checkOutput("t6_w1", logQ[base+1], {32'h42424242, 32'd1, 32'h5A5A5A5A, 32'hA5A5A5A5});
    applyStimulus(32'd1, 32'h77, 2'd3);
    waitIdle("t6_idle");
    checkOutput("t6_new_w0", logQ[base+2], {32'h42424242, 32'd0, 32'hFFFFFF88, 32'h00000077});
    checkOutput("t6_new_trl", logQ[base+3], {32'hDEADBEEF, 32'd1, 32'h0, 32'h00000077});

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
